// File: rtl/seg7_pkg.sv
// seg7_pkg: glyph constants, FSM state type and one-hot helpers for the 7-segment scan reader.
package seg7_pkg;
    localparam logic [6:0] GLYPH_0 = 7'h3F, GLYPH_1 = 7'h06, GLYPH_2 = 7'h5B, GLYPH_3 = 7'h4F,
                           GLYPH_4 = 7'h66, GLYPH_5 = 7'h6D, GLYPH_6 = 7'h7D, GLYPH_7 = 7'h07,
                           GLYPH_8 = 7'h7F, GLYPH_9 = 7'h6F;
    localparam logic [6:0] GLYPH_ALT_6 = 7'h7C, GLYPH_ALT_7 = 7'h27, GLYPH_ALT_9 = 7'h67;
    localparam logic [3:0] BCD_INVALID = 4'hF;

    typedef enum logic [1:0] {IDLE, SETTLE, COMMIT, HOLD} state_t;

    function automatic logic is_onehot(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

    function automatic logic [2:0] onehot_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) if (v[i]) idx = 3'(i);
        return idx;
    endfunction
endpackage

// File: rtl/seg7_scan_reader_if.sv
// seg7_scan_reader_if: frame output handshake (valid/ready with BCD digits, error bits, overflow flag).
interface seg7_scan_reader_if #(parameter int NDIG = 4);
    logic                out_valid;
    logic                out_ready;
    logic [4*NDIG-1:0]   bcd_out;
    logic [NDIG-1:0]     err_out;
    logic                ovf;
    modport master(output out_valid, bcd_out, err_out, ovf, input out_ready);
    modport slave(input out_valid, bcd_out, err_out, ovf, output out_ready);
endinterface

// File: rtl/seg7_glyph_enc.sv
// seg7_glyph_enc: 7-segment pattern -> BCD digit, invalid patterns give 4'hF with err set.
// Define SEG7_ALT_GLYPH_EN to also accept the alternate 6/7/9 glyphs.
module seg7_glyph_enc
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] bcd,
    output logic       err
);
    always_comb begin
        bcd = BCD_INVALID;
        case (seg)
            GLYPH_0: bcd = 4'd0;
            GLYPH_1: bcd = 4'd1;
            GLYPH_2: bcd = 4'd2;
            GLYPH_3: bcd = 4'd3;
            GLYPH_4: bcd = 4'd4;
            GLYPH_5: bcd = 4'd5;
            GLYPH_6: bcd = 4'd6;
            GLYPH_7: bcd = 4'd7;
            GLYPH_8: bcd = 4'd8;
            GLYPH_9: bcd = 4'd9;
`ifdef SEG7_ALT_GLYPH_EN
            GLYPH_ALT_6: bcd = 4'd6;
            GLYPH_ALT_7: bcd = 4'd7;
            GLYPH_ALT_9: bcd = 4'd9;
`else
`endif
            default: bcd = BCD_INVALID;
        endcase
    end

    assign err = (bcd == BCD_INVALID);
endmodule

// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: decodes a multiplexed 7-segment bus back into a frame of BCD digits.
// Glyph acceptance is switched by SEG7_ALT_GLYPH_EN inside seg7_glyph_enc.
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [6:0]      seg_in,
    input  logic [NDIG-1:0] dig_sel,
    seg7_scan_reader_if.master bus
);
    localparam int IW = $clog2(NDIG);
    localparam int CW = $clog2(STABLE_CYC + 1);
    localparam logic [CW-1:0] STABLE = CW'(STABLE_CYC);
    localparam state_t START = (STABLE_CYC == 1) ? COMMIT : SETTLE;

    logic [6:0]        seg_m, seg_s, seg_p;
    logic [NDIG-1:0]   sel_m, sel_s, sel_p;
    logic [CW-1:0]     cnt;
    state_t            state;
    logic [NDIG-1:0]   mask, frame_err;
    logic [4*NDIG-1:0] frame_bcd;
    logic              same, sel_ok, enc_err;
    logic [3:0]        enc_bcd;
    logic [IW-1:0]     idx;

    assign same   = {seg_s, sel_s} == {seg_p, sel_p};
    assign sel_ok = is_onehot(8'(sel_s));
    assign idx    = IW'(onehot_index(8'(sel_p)));

    seg7_glyph_enc u_enc (.seg(seg_p), .bcd(enc_bcd), .err(enc_err));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {seg_m, seg_s, seg_p} <= '0;
            {sel_m, sel_s, sel_p} <= '0;
            cnt           <= '0;
            state         <= IDLE;
            mask          <= '0;
            frame_bcd     <= '0;
            frame_err     <= '0;
            bus.out_valid <= 1'b0;
            bus.bcd_out   <= '0;
            bus.err_out   <= '0;
            bus.ovf       <= 1'b0;
        end else begin
            seg_m <= seg_in;
            seg_s <= seg_m;
            sel_m <= dig_sel;
            sel_s <= sel_m;
            // seg_p/sel_p hold the sample being qualified (SETTLE) or already committed (HOLD)
            case (state)
                IDLE: if (sel_ok) begin
                    state <= START;
                    cnt   <= CW'(1);
                    seg_p <= seg_s;
                    sel_p <= sel_s;
                end
                SETTLE: begin
                    seg_p <= seg_s;
                    sel_p <= sel_s;
                    if (!same) begin
                        state <= sel_ok ? START : IDLE;
                        cnt   <= CW'(1);
                    end else if (cnt + 1'b1 == STABLE) state <= COMMIT;
                    else cnt <= cnt + 1'b1;
                end
                COMMIT: begin
                    frame_bcd[{idx, 2'b00} +: 4] <= enc_bcd;
                    frame_err[idx]               <= enc_err;
                    mask[idx]                    <= 1'b1;
                    state                        <= HOLD;
                end
                HOLD: if (!same) begin
                    state <= sel_ok ? START : IDLE;
                    cnt   <= CW'(1);
                    seg_p <= seg_s;
                    sel_p <= sel_s;
                end
                default: state <= IDLE;
            endcase
            if (bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
                bus.ovf       <= 1'b0;
            end
            // a full mask only appears the cycle after a COMMIT, so no commit collides with this clear
            if (&mask) begin
                mask <= '0;
                if (!bus.out_valid || bus.out_ready) begin
                    bus.bcd_out   <= frame_bcd;
                    bus.err_out   <= frame_err;
                    bus.out_valid <= 1'b1;
                end else bus.ovf <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seg7_scan_reader.sv
// tb_seg7_scan_reader: glyph table, directed corner sequences and random scans against a frame model.
// Expected glyph results follow SEG7_ALT_GLYPH_EN when it is defined for the build.
module tb_seg7_scan_reader;
    localparam int NDIG   = 4;
    localparam int STABLE = 3;

    typedef struct packed {logic [15:0] bcd; logic [3:0] err;} frame_t;
    typedef struct {logic [6:0] seg; logic [3:0] bcd; logic err;} vec_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [6:0] seg_in = '0;
    logic [NDIG-1:0] dig_sel = '0;
    int checks = 0, failures = 0, vcnt = 0;
    frame_t rcv[$], exp_q[$];
    logic hold_pend = 1'b0;
    logic [15:0] hold_bcd = '0;

    seg7_scan_reader_if #(.NDIG(NDIG)) bus();
    seg7_scan_reader #(.NDIG(NDIG), .STABLE_CYC(STABLE)) dut (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .dig_sel(dig_sel), .bus(bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) hold_pend = 1'b0;
        else begin
            if (hold_pend && bus.out_valid) chk("hold_stable", 32'(bus.bcd_out), 32'(hold_bcd));
            if (bus.out_valid) vcnt++;
            if (bus.out_valid && bus.out_ready) rcv.push_back({bus.bcd_out, bus.err_out});
            hold_pend = bus.out_valid && !bus.out_ready;
            hold_bcd  = bus.bcd_out;
        end
    end

    function automatic logic [4:0] ref_dec(input logic [6:0] s);
        logic [6:0] g[10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        for (int i = 0; i < 10; i++) if (s == g[i]) return {1'b0, 4'(i)};
`ifdef SEG7_ALT_GLYPH_EN
        if (s == 7'h7C) return 5'h06;
        if (s == 7'h27) return 5'h07;
        if (s == 7'h67) return 5'h09;
`endif
        return 5'h1F;
    endfunction

    task automatic drive(input logic [6:0] s, input logic [3:0] sel, input int n);
        seg_in  = s;
        dig_sel = sel;
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic scan(input logic [27:0] g, input int hold);
        for (int d = 0; d < 4; d++) drive(g[7*d +: 7], 4'(1 << d), hold);
        drive(7'h00, 4'h0, 3);
    endtask

    task automatic wait_frames(input int n);
        int t = 0;
        do begin
            @(posedge clk);
            t++;
        end while (rcv.size() < n && t < 200);
        #2;
        chk("frame_arrived", 32'(rcv.size() >= n), 32'd1);
    endtask

    initial begin
        vec_t vt[15];
        logic [27:0] g;
        logic [15:0] eb, mb;
        logic [3:0] mask, me, sel, psel;
        logic [6:0] s, ps;
        logic [4:0] d;
        int k, dur;
        logic [6:0] valid_g[10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        logic [3:0] multi[4] = '{4'b0011, 4'b0101, 4'b1111, 4'b0110};
`ifdef SEG7_ALT_GLYPH_EN
        logic alt = 1'b1;
`else
        logic alt = 1'b0;
`endif
        vt = '{'{7'h3F, 4'h0, 1'b0}, '{7'h06, 4'h1, 1'b0}, '{7'h5B, 4'h2, 1'b0}, '{7'h4F, 4'h3, 1'b0},
               '{7'h66, 4'h4, 1'b0}, '{7'h6D, 4'h5, 1'b0}, '{7'h7D, 4'h6, 1'b0}, '{7'h07, 4'h7, 1'b0},
               '{7'h7F, 4'h8, 1'b0}, '{7'h6F, 4'h9, 1'b0},
               '{7'h7C, alt ? 4'h6 : 4'hF, !alt}, '{7'h27, alt ? 4'h7 : 4'hF, !alt},
               '{7'h67, alt ? 4'h9 : 4'hF, !alt}, '{7'h00, 4'hF, 1'b1}, '{7'h79, 4'hF, 1'b1}};
        bus.out_ready = 1'b1;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_bcd", 32'(bus.bcd_out), 0);
        chk("rst_err", 32'(bus.err_out), 0);
        chk("rst_ovf", 32'(bus.ovf), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        drive(7'h00, 4'h0, 2);

        // basic scan, one pulse
        rcv.delete();
        vcnt = 0;
        scan({7'h7D, 7'h6D, 7'h66, 7'h4F}, 8);
        wait_frames(1);
        drive(7'h00, 4'h0, 5);
        chk("t1_pulses", 32'(vcnt), 1);
        if (rcv.size() > 0) begin
            chk("t1_bcd", 32'(rcv[0].bcd), 32'h6543);
            chk("t1_err", 32'(rcv[0].err), 0);
        end

        // glyph table, test glyph rotated across slots
        for (int i = 0; i < 15; i++) begin
            k = i % 4;
            g = {4{7'h7F}};
            g[7*k +: 7] = vt[i].seg;
            eb = 16'h8888;
            eb[4*k +: 4] = vt[i].bcd;
            rcv.delete();
            scan(g, 6);
            wait_frames(1);
            if (rcv.size() > 0) begin
                chk($sformatf("glyph_bcd_%h", vt[i].seg), 32'(rcv[0].bcd), 32'(eb));
                chk($sformatf("glyph_err_%h", vt[i].seg), 32'(rcv[0].err), 32'(4'(vt[i].err) << k));
            end
        end

        // short glitch on digit 0 before the real glyph
        rcv.delete();
        drive(7'h3F, 4'h1, 2);
        drive(7'h06, 4'h1, 6);
        drive(7'h5B, 4'h2, 8);
        drive(7'h4F, 4'h4, 8);
        drive(7'h66, 4'h8, 8);
        drive(7'h00, 4'h0, 3);
        wait_frames(1);
        drive(7'h00, 4'h0, 10);
        chk("t2_frames", 32'(rcv.size()), 1);
        if (rcv.size() > 0) chk("t2_bcd", 32'(rcv[0].bcd), 32'h4321);

        // alternate 6 on digit 2
        rcv.delete();
        scan({7'h66, 7'h7C, 7'h5B, 7'h06}, 8);
        wait_frames(1);
        if (rcv.size() > 0) begin
            chk("t3_bcd", 32'(rcv[0].bcd), alt ? 32'h4621 : 32'h4F21);
            chk("t3_err", 32'(rcv[0].err), alt ? 32'h0 : 32'h4);
        end

        // backpressure: second frame dropped, ovf set then cleared on handshake
        bus.out_ready = 1'b0;
        scan({7'h66, 7'h4F, 7'h5B, 7'h06}, 8);
        chk("t4_valid", 32'(bus.out_valid), 1);
        chk("t4_bcd_a", 32'(bus.bcd_out), 32'h4321);
        chk("t4_ovf_pre", 32'(bus.ovf), 0);
        scan({7'h07, 7'h7D, 7'h6D, 7'h66}, 8);
        chk("t4_bcd_held", 32'(bus.bcd_out), 32'h4321);
        chk("t4_ovf_set", 32'(bus.ovf), 1);
        rcv.delete();
        bus.out_ready = 1'b1;
        drive(7'h00, 4'h0, 1);
        chk("t4_hs_count", 32'(rcv.size()), 1);
        if (rcv.size() > 0) chk("t4_hs_bcd", 32'(rcv[0].bcd), 32'h4321);
        chk("t4_valid_low", 32'(bus.out_valid), 0);
        chk("t4_ovf_clr", 32'(bus.ovf), 0);

        // illegal selects between digits
        rcv.delete();
        drive(7'h4F, 4'h1, 8);
        drive(7'h06, 4'h3, 5);
        drive(7'h06, 4'h0, 5);
        drive(7'h66, 4'h2, 8);
        drive(7'h3F, 4'h3, 5);
        drive(7'h00, 4'h0, 5);
        drive(7'h6D, 4'h4, 8);
        drive(7'h7F, 4'hC, 5);
        drive(7'h7D, 4'h8, 8);
        drive(7'h00, 4'h0, 3);
        wait_frames(1);
        drive(7'h00, 4'h0, 10);
        chk("t5_frames", 32'(rcv.size()), 1);
        if (rcv.size() > 0) chk("t5_bcd", 32'(rcv[0].bcd), 32'h6543);

        // reset with a pending frame and a partial frame
        bus.out_ready = 1'b0;
        scan({7'h06, 7'h06, 7'h06, 7'h06}, 6);
        drive(7'h5B, 4'h1, 8);
        drive(7'h4F, 4'h2, 8);
        #4 rst_n = 1'b0;
        #1;
        chk("t6_valid", 32'(bus.out_valid), 0);
        chk("t6_bcd", 32'(bus.bcd_out), 0);
        chk("t6_err", 32'(bus.err_out), 0);
        chk("t6_ovf", 32'(bus.ovf), 0);
        seg_in = '0;
        dig_sel = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        rcv.delete();
        drive(7'h00, 4'h0, 2);
        drive(7'h6F, 4'h4, 8);
        drive(7'h3F, 4'h8, 8);
        drive(7'h00, 4'h0, 6);
        chk("t6_partial", 32'(rcv.size()), 0);
        drive(7'h07, 4'h1, 8);
        drive(7'h7D, 4'h2, 8);
        drive(7'h00, 4'h0, 3);
        wait_frames(1);
        if (rcv.size() > 0) chk("t6_bcd_new", 32'(rcv[0].bcd), 32'h0967);

        // random scans against the frame model
        rcv.delete();
        exp_q.delete();
        mask = '0;
        mb = '0;
        me = '0;
        ps = '0;
        psel = '0;
        for (int i = 0; i < 400; i++) begin
            do begin
                sel = ($urandom_range(0, 9) < 8) ? 4'(1 << $urandom_range(0, 3))
                      : (($urandom_range(0, 1) == 0) ? 4'h0 : multi[$urandom_range(0, 3)]);
                s = ($urandom_range(0, 9) < 7) ? valid_g[$urandom_range(0, 9)] : 7'($urandom);
            end while ({s, sel} == {ps, psel});
            dur = ($urandom_range(0, 2) == 0) ? $urandom_range(1, STABLE - 1)
                  : $urandom_range(STABLE + 2, STABLE + 6);
            if ($countones(sel) == 1 && dur >= STABLE) begin
                for (int j = 0; j < 4; j++) if (sel[j]) k = j;
                d = ref_dec(s);
                mb[4*k +: 4] = d[3:0];
                me[k] = d[4];
                mask[k] = 1'b1;
                if (&mask) begin
                    exp_q.push_back({mb, me});
                    mask = '0;
                end
            end
            drive(s, sel, dur);
            ps = s;
            psel = sel;
        end
        drive(7'h00, 4'h0, 10);
        chk("rand_count", 32'(rcv.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rcv.size(); i++)
            chk($sformatf("rand_frame_%0d", i), 32'(rcv[i]), 32'(exp_q[i]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
